// File: rtl/inst_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg: shared constants and fetch state encoding.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package inst_fetch_ctrl_pkg;
  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam logic [INST_W-1:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/inst_fetch_ctrl_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf: one-entry {inst, pc} holding buffer with load/pop/flush.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf
  import inst_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_full,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_full;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;

  // Load wins over pop so a pop and refill in the same cycle keeps the entry full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl: PC sequencing, memory read issue and valid/ready delivery.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [31:0]       o_addr,
  output logic              o_rd_en,
  input  logic [INST_W-1:0] i_inst,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_halted,
  output logic [15:0]       o_fetch_count
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_flight_pc, r_out_pc;
  logic              r_flight, r_out_valid;
  logic [INST_W-1:0] r_out_inst;
  logic [15:0]       r_count;

  logic              w_skid_full, w_skid_load, w_skid_pop, w_skid_flush;
  logic [INST_W-1:0] w_skid_inst;
  logic [ADDR_W-1:0] w_skid_pc;

  logic w_active, w_start, w_redirect, w_accept, w_out_free;
  logic w_ret, w_ret_halt, w_ret_ok, w_rd_en, w_last;

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start    = i_start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
  assign w_redirect = i_redirect && w_active;
  assign w_accept   = r_out_valid && i_ready;
  assign w_out_free = !r_out_valid || w_accept;
  assign w_ret      = r_flight && !w_redirect;
  assign w_ret_halt = w_ret && (i_inst == HALT_WORD);
  assign w_ret_ok   = w_ret && !w_ret_halt;
  assign w_last     = (r_pc == {ADDR_W{1'b1}});
  // Hold off when a stalled output plus an in-flight word would leave no room for another.
  assign w_rd_en    = (r_state == ST_RUN) && !w_redirect && !w_skid_full &&
                      !(r_out_valid && !i_ready && r_flight);

  assign w_skid_flush = w_redirect;
  assign w_skid_pop   = !w_redirect && w_out_free && w_skid_full;
  assign w_skid_load  = w_ret_ok && (!w_out_free || w_skid_full);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_flush (w_skid_flush),
    .i_inst  (i_inst),
    .i_pc    (r_flight_pc),
    .o_full  (w_skid_full),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_halted    = (r_state == ST_HALTED);
    case (r_state)
      ST_IDLE, ST_HALTED: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_redirect)              w_state_nxt = ST_RUN;
        else if (w_ret_halt)         w_state_nxt = ST_DRAIN;
        else if (w_rd_en && w_last)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_redirect) w_state_nxt = ST_RUN;
        else if (!r_out_valid && !w_skid_full && !r_flight) w_state_nxt = ST_HALTED;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_flight    <= 1'b0;
      r_flight_pc <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_count     <= '0;
    end else begin
      if (w_start) begin
        r_pc    <= '0;
        r_count <= '0;
      end else begin
        if (w_redirect)   r_pc <= i_target;
        else if (w_rd_en) r_pc <= r_pc + 1'b1;
        if (w_accept && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
      end

      // A read issued alongside a returning halt word is squashed here.
      if (w_redirect || w_ret_halt) r_flight <= 1'b0;
      else                          r_flight <= w_rd_en;
      if (w_rd_en) r_flight_pc <= r_pc;

      if (w_redirect) begin
        r_out_valid <= 1'b0;
      end else if (w_out_free) begin
        if (w_skid_full) begin
          r_out_valid <= 1'b1;
          r_out_inst  <= w_skid_inst;
          r_out_pc    <= w_skid_pc;
        end else if (w_ret_ok) begin
          r_out_valid <= 1'b1;
          r_out_inst  <= i_inst;
          r_out_pc    <= r_flight_pc;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign o_addr        = {{(32-ADDR_W){1'b0}}, r_pc};
  assign o_rd_en       = w_rd_en;
  assign o_inst        = r_out_inst;
  assign o_inst_pc     = r_out_pc;
  assign o_valid       = r_out_valid;
  assign o_fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_ctrl: cycle table plus directed sequences for inst_fetch_ctrl.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] o_addr;
  logic        o_rd_en;
  logic [15:0] i_inst;
  logic [15:0] o_inst;
  logic [7:0]  o_inst_pc;
  logic        o_valid;
  logic        i_ready;
  logic        i_redirect;
  logic [7:0]  i_target;
  logic        o_halted;
  logic [15:0] o_fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [256];
  logic [15:0] r_mem_q;
  int          r_reads;
  logic        r_hi_bad;
  logic        rd_clr;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .o_addr        (o_addr),
    .o_rd_en       (o_rd_en),
    .i_inst        (i_inst),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .i_redirect    (i_redirect),
    .i_target      (i_target),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count)
  );

  // One-cycle-latency instruction memory plus read accounting.
  always @(posedge clk) begin
    if (rd_clr) begin
      r_reads  <= 0;
      r_hi_bad <= 1'b0;
    end else if (o_rd_en) begin
      r_reads <= r_reads + 1;
      if (o_addr[31:8] != 24'd0) r_hi_bad <= 1'b1;
    end
    if (o_rd_en) r_mem_q <= mem[o_addr[7:0]];
  end
  assign i_inst = r_mem_q;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        rdr;
    logic [7:0]  tgt;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_v;
    logic [15:0] e_inst;
    logic [7:0]  e_pc;
    logic        e_h;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic st, rdy, rdr, input logic [7:0] tgt,
                             input logic e_rd, input logic [7:0] e_addr,
                             input logic e_v, input logic [15:0] e_inst,
                             input logic [7:0] e_pc, input logic e_h,
                             input logic [15:0] e_cnt);
    vec_t r;
    r.st = st; r.rdy = rdy; r.rdr = rdr; r.tgt = tgt;
    r.e_rd = e_rd; r.e_addr = e_addr; r.e_v = e_v; r.e_inst = e_inst;
    r.e_pc = e_pc; r.e_h = e_h; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Streams until halt; every accepted word must be the next address in order.
  task automatic run_stream(input int exp_n, input int stall_mod, input int bound, input string tag);
    int idx = 0;
    int cyc = 0;
    while (cyc < bound) begin
      @(posedge clk);
      #1;
      i_ready = (stall_mod == 0) ? 1'b1 : ((cyc % stall_mod) != 0);
      @(negedge clk);
      if (o_valid && i_ready) begin
        chk($sformatf("%s pc[%0d]", tag, idx), {24'd0, o_inst_pc}, idx[31:0]);
        chk($sformatf("%s inst[%0d]", tag, idx), {16'd0, o_inst}, {16'd0, mem[idx[7:0]]});
        idx++;
      end
      if (o_halted) break;
      cyc++;
    end
    i_ready = 1'b1;
    chk({tag, " deliveries"}, idx, exp_n);
    chk({tag, " halted"}, {31'd0, o_halted}, 32'd1);
    chk({tag, " fetch_count"}, {16'd0, o_fetch_count}, exp_n);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_redirect = 1'b0; i_target = 8'd0;
    rd_clr = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hB300; mem[1] = 16'hB200; mem[2] = 16'hB100; mem[3] = 16'h8B11;
    mem[4] = 16'hFFFF; mem[9] = 16'hE00F; mem[10] = 16'h1234; mem[11] = 16'hFFFF;

    //                 st rdy rdr tgt  rd addr  v inst      pc  h cnt
    vecs.push_back(v(1, 1, 0, 0,   0, 0,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 0,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 1,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 2,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 3,    1, 16'hB200, 1,  0, 1));
    vecs.push_back(v(0, 1, 0, 0,   1, 4,    1, 16'hB100, 2,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 5,    1, 16'h8B11, 3,  0, 3));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  0, 4));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  1, 4));
    // stall three cycles after first valid
    vecs.push_back(v(1, 1, 0, 0,   0, 0,    0, 16'h0,    0,  1, 4));
    vecs.push_back(v(0, 1, 0, 0,   1, 0,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 1,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 2,    1, 16'hB200, 1,  0, 1));
    vecs.push_back(v(0, 1, 0, 0,   1, 3,    0, 16'h0,    0,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 4,    1, 16'hB100, 2,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 5,    1, 16'h8B11, 3,  0, 3));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  0, 4));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  1, 4));
    // redirect to 9 while streaming
    vecs.push_back(v(1, 1, 0, 0,   0, 0,    0, 16'h0,    0,  1, 4));
    vecs.push_back(v(0, 1, 0, 0,   1, 0,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 1,    0, 16'h0,    0,  0, 0));
    vecs.push_back(v(0, 1, 0, 0,   1, 2,    1, 16'hB300, 0,  0, 0));
    vecs.push_back(v(0, 1, 1, 9,   0, 0,    1, 16'hB200, 1,  0, 1));
    vecs.push_back(v(0, 1, 0, 0,   1, 9,    0, 16'h0,    0,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 10,   0, 16'h0,    0,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 11,   1, 16'hE00F, 9,  0, 2));
    vecs.push_back(v(0, 1, 0, 0,   1, 12,   1, 16'h1234, 10, 0, 3));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  0, 4));
    vecs.push_back(v(0, 1, 0, 0,   0, 0,    0, 16'h0,    0,  1, 4));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rd_clr = 1'b0;
    @(negedge clk);
    chk("reset valid", {31'd0, o_valid}, 32'd0);
    chk("reset rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("reset addr", o_addr, 32'd0);
    chk("reset count", {16'd0, o_fetch_count}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      i_start = vecs[i].st; i_ready = vecs[i].rdy;
      i_redirect = vecs[i].rdr; i_target = vecs[i].tgt;
      @(negedge clk);
      chk($sformatf("row%0d rd_en", i), {31'd0, o_rd_en}, {31'd0, vecs[i].e_rd});
      if (vecs[i].e_rd) chk($sformatf("row%0d addr", i), o_addr, {24'd0, vecs[i].e_addr});
      chk($sformatf("row%0d valid", i), {31'd0, o_valid}, {31'd0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        chk($sformatf("row%0d inst", i), {16'd0, o_inst}, {16'd0, vecs[i].e_inst});
        chk($sformatf("row%0d inst_pc", i), {24'd0, o_inst_pc}, {24'd0, vecs[i].e_pc});
      end
      chk($sformatf("row%0d halted", i), {31'd0, o_halted}, {31'd0, vecs[i].e_h});
      chk($sformatf("row%0d count", i), {16'd0, o_fetch_count}, {16'd0, vecs[i].e_cnt});
    end

    // start together with redirect while halted: redirect must be ignored
    @(posedge clk); #1 i_start = 1'b1; i_redirect = 1'b1; i_target = 8'd9;
    @(posedge clk); #1 i_start = 1'b0; i_redirect = 1'b0;
    @(negedge clk);
    chk("restart rd_en", {31'd0, o_rd_en}, 32'd1);
    chk("restart addr", o_addr, 32'd0);
    chk("restart halted", {31'd0, o_halted}, 32'd0);
    run_stream(4, 0, 100, "restart");

    // reset with output held and skid full
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 i_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("pre-rst valid", {31'd0, o_valid}, 32'd1);
    chk("pre-rst inst_pc", {24'd0, o_inst_pc}, 32'd1);
    chk("pre-rst rd_en", {31'd0, o_rd_en}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("rst valid", {31'd0, o_valid}, 32'd0);
    chk("rst inst", {16'd0, o_inst}, 32'd0);
    chk("rst inst_pc", {24'd0, o_inst_pc}, 32'd0);
    chk("rst rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("rst addr", o_addr, 32'd0);
    chk("rst halted", {31'd0, o_halted}, 32'd0);
    chk("rst count", {16'd0, o_fetch_count}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle rd_en", {31'd0, o_rd_en}, 32'd0);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    chk("post-rst rd_en", {31'd0, o_rd_en}, 32'd1);
    chk("post-rst addr", o_addr, 32'd0);
    run_stream(4, 3, 100, "post-rst");

    // full memory without a halt word, with periodic stalls
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 ^ 16'(i);
    @(posedge clk); #1 rd_clr = 1'b1; i_start = 1'b1;
    @(posedge clk); #1 rd_clr = 1'b0; i_start = 1'b0;
    run_stream(256, 4, 1000, "fullmem");
    chk("fullmem reads", r_reads, 256);
    chk("fullmem addr high", {31'd0, r_hi_bad}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
